alu_pipe: RTL

Parametrised, handshaked successor to the core's combinational ALU. Accepts one operation at a time over a valid/ready interface and produces a registered result with N/Z/C/V flags. Single-cycle ops complete in one cycle; unsigned multiply uses an iterative multi-cycle datapath. Sits between the issue stage and writeback and may apply backpressure in both directions.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_pipe_mul.sv | 71 +++++++
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: function codes, flag bit positions
// and the control FSM state type.
package alu_pkg;

  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 6'h20;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 6'h22;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 6'h24;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 6'h25;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 6'h26;
  localparam logic [FUNC_W-1:0] FUNC_SLT  = 6'h2A;
  localparam logic [FUNC_W-1:0] FUNC_SLTU = 6'h2B;
  localparam logic [FUNC_W-1:0] FUNC_SLL  = 6'h00;
  localparam logic [FUNC_W-1:0] FUNC_SRL  = 6'h02;
  localparam logic [FUNC_W-1:0] FUNC_SRA  = 6'h03;
  localparam logic [FUNC_W-1:0] FUNC_MULU = 6'h19;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add unsigned multiplier: the first step is folded into the
// start edge, so the full product and a one-cycle done pulse appear WIDTH-1 edges later.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  // One step: conditionally add the multiplicand into the high half, then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : (WIDTH+1)'(0));
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start_i) begin
      mcand_d = mcand_i;
      prod_d  = mul_step({WIDTH'(0), mplier_i}, mcand_i);
      cnt_d   = CNT_W'(1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d = mul_step(prod_q, mcand_q);
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in the output register at the accept
// edge; MULU runs on the iterative multiplier while the FSM sits in BUSY.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [FUNC_W-1:0]   func,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    result_hi,
  output logic [FLAGS_W-1:0]  flags,
  output logic                err
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned MSB  = WIDTH - 1;

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic [FLAGS_W-1:0]   flags_q, flags_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [FLAGS_W-1:0]   mul_flags;

  logic [WIDTH:0]       sum, diff;
  logic [SH_W-1:0]      shamt;
  logic [WIDTH-1:0]     alu_res;
  logic [FLAGS_W-1:0]   alu_flags;
  logic                 alu_c, alu_v, alu_err;

  assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (func == FUNC_MULU);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .mcand_i  (operand_a),
    .mplier_i (operand_b),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  // Single-cycle datapath, evaluated on the operands presented at the accept edge.
  always_comb begin
    sum     = {1'b0, operand_a} + {1'b0, operand_b};
    diff    = {1'b0, operand_a} - {1'b0, operand_b};
    shamt   = operand_b[SH_W-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (func)
      FUNC_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
      end
      FUNC_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
      end
      FUNC_AND:  alu_res = operand_a & operand_b;
      FUNC_OR:   alu_res = operand_a | operand_b;
      FUNC_XOR:  alu_res = operand_a ^ operand_b;
      FUNC_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      FUNC_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      FUNC_SLL:  alu_res = operand_a << shamt;
      FUNC_SRL:  alu_res = operand_a >> shamt;
      FUNC_SRA:  alu_res = WIDTH'($signed(operand_a) >>> shamt);
      FUNC_MULU: alu_res = '0;
      default:   alu_err = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[MSB];
    mul_flags[FLAG_Z] = (mul_prod == '0);
    mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  // Control FSM and output register; drain and a new accept may share an edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (func == FUNC_MULU) begin
            state_d = BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = alu_flags;
            err_d       = alu_err;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_prod[WIDTH-1:0];
          result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          flags_d     = mul_flags;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
